// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer: fetches 8-bit instruction words, strobes the
// decode stage for one cycle per instruction, and updates the PC for
// sequential flow, conditional relative branches and halt.
module instr_fetch #(
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [3:0]      flags,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [7:0]      mem_rdata,
    output logic [3:0]      OPcode,
    output logic [3:0]      operand,
    output logic            en,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    localparam logic [PC_W-1:0] LP_RESET_PC = PC_W'(RESET_PC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [7:0]      r_ir;
    logic            w_ir_load;
    logic            w_take;
    logic [PC_W-1:0] w_imm_sext;

    // flags are {N,Z,C,V}; opcode bits [2:0] select the branch condition
    always_comb begin
        w_take = 1'b0;
        case (r_ir[6:4])
            3'b000:  w_take = 1'b1;
            3'b001:  w_take = flags[2];
            3'b010:  w_take = ~flags[2];
            3'b011:  w_take = flags[3];
            3'b100:  w_take = ~flags[3];
            3'b101:  w_take = flags[1];
            3'b110:  w_take = flags[0];
            default: w_take = 1'b0;
        endcase
    end

    assign w_imm_sext = PC_W'($signed(r_ir[3:0]));

    // next state, next PC and IR capture enable
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_ir[7:4] == 4'hF) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt = ST_FETCH;
                    if (r_ir[7] && w_take) begin
                        w_pc_nxt = r_pc + w_imm_sext;
                    end else begin
                        w_pc_nxt = r_pc + PC_W'(1);
                    end
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // state, PC and IR registers; reset wins over any coincident ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= LP_RESET_PC;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_ir_load) begin
                r_ir <= mem_rdata;
            end
        end
    end

    assign mem_req  = (r_state == ST_FETCH);
    assign mem_addr = r_pc;
    assign en       = (r_state == ST_EXEC);
    assign halted   = (r_state == ST_HALT);
    assign pc       = r_pc;
    assign OPcode   = r_ir[7:4];
    assign operand  = r_ir[3:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-level model predicts the
// fetch-address and executed-instruction streams; a monitor checks them.
module tb_instr_fetch;

    localparam int PC_W     = 8;
    localparam int RESET_PC = 0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            run = 1'b0;
    logic [3:0]      flags = '0;
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic            mem_ack = 1'b0;
    logic [7:0]      mem_rdata = '0;
    logic [3:0]      OPcode;
    logic [3:0]      operand;
    logic            en;
    logic [PC_W-1:0] pc;
    logic            halted;

    always #5 clk = ~clk;

    instr_fetch #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .run(run), .flags(flags),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .OPcode(OPcode), .operand(operand),
        .en(en), .pc(pc), .halted(halted)
    );

    typedef struct {
        int op;
        int imm;
        int pc;
    } exec_t;

    int    fq[$];
    exec_t eq[$];

    logic [7:0] mem [256];
    logic [3:0] fseq [512];

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;   // 0 quiet, 1 memory responder, 2 random noise, 3 forced ack
    int lat_min  = 1;
    int lat_max  = 1;
    int exp_period = 0;
    int halt_pc  = 0;
    bit exp_halt = 1'b0;

    // responder state
    int k = 0, wcnt = 0, lat = 1;
    // monitor state
    int mcyc = 0, last_en = -1, last_ack = -100, last_op = 0, last_imm = 0;
    bit prev_req = 1'b0, prev_en = 1'b0, have_ir = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Instruction-level semantics: returns the PC after executing instr at p.
    function automatic int model_next(input int p, input int instr, input int f, output bit halt);
        int op, imm, simm, m;
        bit take;
        m    = 1 << PC_W;
        op   = instr / 16;
        imm  = instr % 16;
        halt = 1'b0;
        take = 1'b0;
        if (op < 8) return (p + 1) % m;
        case (op - 8)
            0: take = 1'b1;
            1: take = ((f >> 2) & 1) == 1;
            2: take = ((f >> 2) & 1) == 0;
            3: take = ((f >> 3) & 1) == 1;
            4: take = ((f >> 3) & 1) == 0;
            5: take = ((f >> 1) & 1) == 1;
            6: take = (f & 1) == 1;
            default: begin
                halt = 1'b1;
                return p;
            end
        endcase
        simm = (imm >= 8) ? imm - 16 : imm;
        if (take) return (p + simm + m) % m;
        return (p + 1) % m;
    endfunction

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1; mode = 0; run = 1'b0;
        @(negedge clk); #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_en", en, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_opcode", OPcode, 0);
        chk("rst_operand", operand, 0);
        rst = 1'b0;
        repeat ($urandom_range(4, 1)) begin
            @(negedge clk); #1;
            chk("idle_no_fetch", mem_req, 0);
            chk("idle_pc", pc, RESET_PC);
        end
    endtask

    task automatic run_scen(input int n_max, input int lmin, input int lmax);
        int p, instr, nxt, budget;
        bit h, done;
        exec_t e;
        lat_min = lmin;
        lat_max = lmax;
        do_reset();
        exp_period = (lmin == lmax) ? lmin + 2 : 0;
        exp_halt = 1'b0;
        p = RESET_PC;
        for (int i = 0; i < n_max; i++) begin
            fq.push_back(p);
            instr = int'(mem[p]);
            e.op = instr / 16; e.imm = instr % 16; e.pc = p;
            eq.push_back(e);
            nxt = model_next(p, instr, int'(fseq[i % 512]), h);
            if (h) begin
                exp_halt = 1'b1;
                halt_pc = p;
                break;
            end
            p = nxt;
        end
        budget = n_max * (lmax + 3) + 20;
        mode = 1; run = 1'b1;
        @(negedge clk); #1;
        run = 1'b0;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #3;
            if (eq.size() == 0 && fq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            chk("scenario_timeout_pending", eq.size() + fq.size(), 0);
            fq.delete();
            eq.delete();
        end else if (exp_halt) begin
            mode = 2;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk); #1;
                run = 1'($urandom_range(1));
                chk("halt_halted", halted, 1);
                chk("halt_mem_req", mem_req, 0);
                chk("halt_en", en, 0);
                chk("halt_pc", pc, halt_pc);
            end
            run = 1'b0;
        end
        rst = 1'b1;
        mode = 0;
    endtask

    task automatic reset_during_fetch();
        bit seen;
        lat_min = 1;
        lat_max = 1;
        do_reset();
        exp_period = 0;
        fq.push_back(RESET_PC);
        mode = 0; run = 1'b1;
        @(negedge clk); #1;
        run = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        chk("fetch_started", seen, 1);
        @(negedge clk); #1;
        mode = 3;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_drops_req", mem_req, 0);
        chk("rst_fetch_pc", pc, RESET_PC);
        chk("rst_fetch_opcode", OPcode, 0);
        chk("rst_fetch_en", en, 0);
        chk("rst_fetch_halted", halted, 0);
        mode = 0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            chk("post_rst_idle", mem_req, 0);
            chk("ack_discarded_opcode", OPcode, 0);
            chk("ack_discarded_operand", operand, 0);
        end
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            // memory responder: acks lat cycles after the request first appears
            forever begin
                @(negedge clk);
                mem_ack = 1'b0;
                case (mode)
                    1: begin
                        if (mem_req) begin
                            if (wcnt >= lat) begin
                                mem_ack   = 1'b1;
                                mem_rdata = mem[mem_addr];
                                flags     = fseq[k % 512];
                                k++;
                                wcnt = 0;
                                lat  = $urandom_range(lat_max, lat_min);
                            end else begin
                                wcnt++;
                            end
                        end else begin
                            wcnt = 0;
                            if (en && $urandom_range(3) == 0) begin
                                mem_ack   = 1'b1;
                                mem_rdata = 8'($urandom);
                            end
                        end
                    end
                    2: begin
                        mem_ack   = 1'($urandom_range(1));
                        mem_rdata = 8'($urandom);
                        flags     = 4'($urandom);
                    end
                    3: begin
                        mem_ack   = 1'b1;
                        mem_rdata = 8'hA5;
                    end
                    default: begin
                        k = 0; wcnt = 0; lat = lat_min;
                    end
                endcase
            end
            // monitor: checks every fetch request and every execute strobe
            forever begin
                exec_t e;
                @(negedge clk); #2;
                mcyc++;
                if (rst) begin
                    last_en = -1; last_ack = -100;
                    prev_req = 1'b0; prev_en = 1'b0; have_ir = 1'b0;
                end else begin
                    if (mem_req) chk("addr_eq_pc", mem_addr, pc);
                    if (mem_req && mem_ack) last_ack = mcyc;
                    if (mem_req && !prev_req) begin
                        if (fq.size() == 0) chk("unexpected_fetch", 1, 0);
                        else chk("fetch_addr", mem_addr, fq.pop_front());
                        if (last_en >= 0) chk("en_to_req_cycles", mcyc - last_en, 1);
                        if (have_ir) begin
                            chk("opcode_stable", OPcode, last_op);
                            chk("operand_stable", operand, last_imm);
                        end
                    end
                    if (en) begin
                        chk("en_not_consecutive", prev_en, 0);
                        if (mode == 1) chk("ack_to_en_cycles", mcyc - last_ack, 1);
                        if (exp_period != 0 && last_en >= 0) chk("en_period", mcyc - last_en, exp_period);
                        if (eq.size() == 0) begin
                            chk("unexpected_en", 1, 0);
                        end else begin
                            e = eq.pop_front();
                            chk("exec_opcode", OPcode, e.op);
                            chk("exec_operand", operand, e.imm);
                            chk("exec_pc", pc, e.pc);
                        end
                        last_en = mcyc; last_op = OPcode; last_imm = operand; have_ir = 1'b1;
                    end
                    prev_req = mem_req;
                    prev_en  = en;
                end
            end
        join_none

        // first instruction with 3-cycle fetch, then halt
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        for (int i = 0; i < 512; i++) fseq[i] = 4'h0;
        mem[0] = 8'h12;
        mem[1] = 8'hF0;
        run_scen(5, 2, 2);

        // branch-if-Z with imm=-2 at pc=5: taken with Z=1, then not taken
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        for (int i = 0; i < 512; i++) fseq[i] = 4'($urandom);
        mem[5] = 8'h9E;
        mem[6] = 8'hF0;
        fseq[5] = 4'b0100;
        fseq[8] = 4'b0000;
        run_scen(20, 1, 3);

        // straight-line code wrapping past the top of memory, minimum latency
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        run_scen(300, 1, 1);

        // random programs, halts allowed
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
            for (int i = 0; i < 512; i++) fseq[i] = 4'($urandom);
            run_scen(150, 1, 4);
        end

        // random long program with halt opcodes turned into non-branches
        for (int a = 0; a < 256; a++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (b[7:4] == 4'hF) b = b ^ 8'h80;
            mem[a] = b;
        end
        for (int i = 0; i < 512; i++) fseq[i] = 4'($urandom);
        run_scen(400, 1, 3);

        reset_during_fetch();

        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
